// File: rtl/rx_pkg.sv
// Shared types and constants for the RS232 command-frame parser.
// Optional checksum byte is enabled by defining RX_CMD_CHECKSUM_EN.
package rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DH   = 3'd2,
        ST_DL   = 3'd3,
`ifdef RX_CMD_CHECKSUM_EN
        ST_CHK  = 3'd4,
`endif
        ST_HOLD = 3'd5
    } rx_state_t;

    localparam logic [1:0] ERR_CHK = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam logic [1:0] ERR_OVR = 2'b11;

    localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

`ifdef RX_CMD_CHECKSUM_EN
    function automatic logic [7:0] frame_xor(input logic [7:0] c,
                                             input logic [7:0] h,
                                             input logic [7:0] l);
        return c ^ h ^ l;
    endfunction
`endif

endpackage

// File: rtl/rx_timeout.sv
// Inter-byte timeout: reloads on clear, counts down while enabled and
// saturates at zero, where expired is flagged.
module rx_timeout #(
    parameter int unsigned CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(CYCLES);
    localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

    logic [W-1:0] cnt_r;

    // Down-counter; holding at zero keeps it from ever wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= {W{1'b0}};
        end else if (clr_i) begin
            cnt_r <= LOAD;
        end else if (en_i && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired_o = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/rx_cmd_parser.sv
// Frame parser: HEADER, CMD, DATA_H, DATA_L [, CHK when RX_CMD_CHECKSUM_EN]
// with valid/ready hand-off, overrun detection and inter-byte timeout.
module rx_cmd_parser
    import rx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  HEADER         = HEADER_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic [7:0]  cmd_o,
    output logic [15:0] data_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    rx_state_t   state_r, state_nxt_s;
    logic [7:0]  cmd_sh_r, cmd_sh_nxt_s;
    logic [7:0]  dh_r, dh_nxt_s;
`ifdef RX_CMD_CHECKSUM_EN
    logic [7:0]  dl_r, dl_nxt_s;
`endif
    logic [7:0]  cmd_r, cmd_nxt_s;
    logic [15:0] data_r, data_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic        err_r, err_nxt_s;
    logic [1:0]  err_code_r, err_code_nxt_s;
    logic        in_frame_s, expired_s, tmo_clr_s, tmo_en_s;

    // Decode the states in which the inter-byte timer runs.
    always_comb begin
        in_frame_s = 1'b0;
        case (state_r)
            ST_CMD, ST_DH, ST_DL: in_frame_s = 1'b1;
`ifdef RX_CMD_CHECKSUM_EN
            ST_CHK:               in_frame_s = 1'b1;
`endif
            default:              in_frame_s = 1'b0;
        endcase
    end

    assign tmo_clr_s = byte_valid_i | ~in_frame_s;
    assign tmo_en_s  = in_frame_s & ~byte_valid_i;

    rx_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (tmo_clr_s),
        .en_i      (tmo_en_s),
        .expired_o (expired_s)
    );

    // Next-state and next-output logic; bytes collect in shadow registers
    // so the visible outputs change only when a frame completes.
    always_comb begin
        state_nxt_s    = state_r;
        cmd_sh_nxt_s   = cmd_sh_r;
        dh_nxt_s       = dh_r;
`ifdef RX_CMD_CHECKSUM_EN
        dl_nxt_s       = dl_r;
`endif
        cmd_nxt_s      = cmd_r;
        data_nxt_s     = data_r;
        err_nxt_s      = 1'b0;
        err_code_nxt_s = err_code_r;
        case (state_r)
            ST_IDLE: begin
                if (byte_valid_i && (byte_i == HEADER)) begin
                    state_nxt_s = ST_CMD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (byte_valid_i) begin
                    cmd_sh_nxt_s = byte_i;
                    state_nxt_s  = ST_DH;
                end else if (expired_s) begin
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = ERR_TMO;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CMD;
                end
            end
            ST_DH: begin
                if (byte_valid_i) begin
                    dh_nxt_s    = byte_i;
                    state_nxt_s = ST_DL;
                end else if (expired_s) begin
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = ERR_TMO;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DH;
                end
            end
            ST_DL: begin
                if (byte_valid_i) begin
`ifdef RX_CMD_CHECKSUM_EN
                    dl_nxt_s    = byte_i;
                    state_nxt_s = ST_CHK;
`else
                    cmd_nxt_s   = cmd_sh_r;
                    data_nxt_s  = {dh_r, byte_i};
                    state_nxt_s = ST_HOLD;
`endif
                end else if (expired_s) begin
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = ERR_TMO;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DL;
                end
            end
`ifdef RX_CMD_CHECKSUM_EN
            ST_CHK: begin
                if (byte_valid_i) begin
                    if (byte_i == frame_xor(cmd_sh_r, dh_r, dl_r)) begin
                        cmd_nxt_s   = cmd_sh_r;
                        data_nxt_s  = {dh_r, dl_r};
                        state_nxt_s = ST_HOLD;
                    end else begin
                        err_nxt_s      = 1'b1;
                        err_code_nxt_s = ERR_CHK;
                        state_nxt_s    = ST_IDLE;
                    end
                end else if (expired_s) begin
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = ERR_TMO;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CHK;
                end
            end
`endif
            ST_HOLD: begin
                // On hand-off the same-cycle byte is treated as an IDLE input.
                if (cmd_ready_i) begin
                    if (byte_valid_i && (byte_i == HEADER)) begin
                        state_nxt_s = ST_CMD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (byte_valid_i) begin
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = ERR_OVR;
                    state_nxt_s    = ST_HOLD;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        valid_nxt_s = (state_nxt_s == ST_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            cmd_sh_r   <= 8'h00;
            dh_r       <= 8'h00;
`ifdef RX_CMD_CHECKSUM_EN
            dl_r       <= 8'h00;
`endif
            cmd_r      <= 8'h00;
            data_r     <= 16'h0000;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
        end else begin
            state_r    <= state_nxt_s;
            cmd_sh_r   <= cmd_sh_nxt_s;
            dh_r       <= dh_nxt_s;
`ifdef RX_CMD_CHECKSUM_EN
            dl_r       <= dl_nxt_s;
`endif
            cmd_r      <= cmd_nxt_s;
            data_r     <= data_nxt_s;
            valid_r    <= valid_nxt_s;
            err_r      <= err_nxt_s;
            err_code_r <= err_code_nxt_s;
        end
    end

    assign cmd_o       = cmd_r;
    assign data_o      = data_r;
    assign cmd_valid_o = valid_r;
    assign err_o       = err_r;
    assign err_code_o  = err_code_r;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Scoreboard bench for rx_cmd_parser; works with or without RX_CMD_CHECKSUM_EN.
module tb_rx_cmd_parser;

    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        err;
    logic [1:0]  err_code;

    typedef struct {
        bit          is_err;
        logic [7:0]  cmd;
        logic [15:0] data;
        logic [1:0]  code;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   total = 0;
    int   bad   = 0;
    logic prev_err = 1'b0;

    rx_cmd_parser #(.TIMEOUT_CYCLES(TMO), .HEADER(8'hAA)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .byte_i       (byte_in),
        .byte_valid_i (byte_valid),
        .cmd_o        (cmd),
        .data_o       (data),
        .cmd_valid_o  (cmd_valid),
        .cmd_ready_i  (cmd_ready),
        .err_o        (err),
        .err_code_o   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] c, input logic [15:0] d);
        exp_t x;
        x.is_err = 1'b0; x.cmd = c; x.data = d; x.code = 2'b00;
        q.push_back(x);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t x;
        x.is_err = 1'b1; x.cmd = 8'h00; x.data = 16'h0000; x.code = code;
        q.push_back(x);
    endtask

    // One strobe, captured by the next rising edge; returns just after it.
    task automatic strobe(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        @(posedge clk) #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk) #1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] k);
        strobe(8'hAA); strobe(c); strobe(h); strobe(l);
`ifdef RX_CMD_CHECKSUM_EN
        strobe(k);
`else
        k = k;
`endif
    endtask

    // Monitor: pop and compare on every transfer and every error pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame actual=%h/%h required=none", cmd, data);
                end else begin
                    e_m = q.pop_front();
                    if (e_m.is_err) begin
                        total++; bad++;
                        $display("FAIL order actual=frame required=err code %b", e_m.code);
                    end else begin
                        check("frame_cmd", {24'h0, cmd}, {24'h0, e_m.cmd});
                        check("frame_data", {16'h0, data}, {16'h0, e_m.data});
                    end
                end
            end
            if (err) begin
                check("err_single_cycle", {31'h0, prev_err}, 32'h0);
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_err actual=code %b required=none", err_code);
                end else begin
                    e_m = q.pop_front();
                    if (!e_m.is_err) begin
                        total++; bad++;
                        $display("FAIL order actual=err %b required=frame", err_code);
                    end else begin
                        check("err_code", {30'h0, err_code}, {30'h0, e_m.code});
                    end
                end
            end
            prev_err <= err;
        end else begin
            prev_err <= 1'b0;
        end
    end

    initial begin
        rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; cmd_ready = 1'b0;
        idle(3);
        check("rst_cmd", {24'h0, cmd}, 32'h0);
        check("rst_data", {16'h0, data}, 32'h0);
        check("rst_valid", {31'h0, cmd_valid}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_code", {30'h0, err_code}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Good frame with ready high: valid for exactly one cycle.
        cmd_ready = 1'b1;
        push_frame(8'h10, 16'h1234);
        send_frame(8'h10, 8'h12, 8'h34, 8'h36);
        check("latency_valid", {31'h0, cmd_valid}, 32'h1);
        idle(1);
        check("valid_one_cycle", {31'h0, cmd_valid}, 32'h0);
        idle(2);

`ifdef RX_CMD_CHECKSUM_EN
        // Bad checksum, then a good frame.
        push_err(2'b01);
        send_frame(8'h10, 8'h12, 8'h34, 8'h27);
        idle(2);
        check("chk_no_valid", {31'h0, cmd_valid}, 32'h0);
        push_frame(8'h5A, 16'h0102);
        send_frame(8'h5A, 8'h01, 8'h02, 8'h59);
        idle(3);
`endif

        // Timeout after AA 10, then the parser is back in IDLE.
        push_err(2'b10);
        strobe(8'hAA); strobe(8'h10);
        idle(TMO + 3);
        check("tmo_code_held", {30'h0, err_code}, 32'h2);
        push_frame(8'h33, 16'hBEEF);
        send_frame(8'h33, 8'hBE, 8'hEF, 8'h62);
        idle(3);

        // Gaps of TMO-1 idle clocks: the strobe lands on the expiry cycle and wins.
        push_frame(8'h44, 16'h5566);
        strobe(8'hAA); strobe(8'h44); idle(TMO - 1); strobe(8'h55); idle(TMO - 1); strobe(8'h66);
`ifdef RX_CMD_CHECKSUM_EN
        idle(TMO - 1); strobe(8'h77);
`endif
        idle(3);

        // Overrun while holding, then hand-off of the intact frame.
        cmd_ready = 1'b0;
        send_frame(8'h10, 8'h12, 8'h34, 8'h36);
        idle(1);
        push_err(2'b11);
        strobe(8'h55);
        idle(2);
        check("ovr_valid_held", {31'h0, cmd_valid}, 32'h1);
        push_frame(8'h10, 16'h1234);
        cmd_ready = 1'b1;
        idle(1);
        cmd_ready = 1'b0;
        idle(2);
        check("ovr_released", {31'h0, cmd_valid}, 32'h0);

        // Header arriving with ready: transfer and go straight to CMD.
        send_frame(8'h10, 8'h12, 8'h34, 8'h36);
        idle(1);
        push_frame(8'h10, 16'h1234);
        cmd_ready = 1'b1;
        strobe(8'hAA);
        push_frame(8'h20, 16'h5678);
        strobe(8'h20); strobe(8'h56); strobe(8'h78);
`ifdef RX_CMD_CHECKSUM_EN
        strobe(8'h0E);
`endif
        idle(3);

        // Reset mid-frame abandons it silently.
        strobe(8'hAA); strobe(8'h10); strobe(8'h12);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd", {24'h0, cmd}, 32'h0);
        check("mid_rst_data", {16'h0, data}, 32'h0);
        check("mid_rst_valid", {31'h0, cmd_valid}, 32'h0);
        check("mid_rst_code", {30'h0, err_code}, 32'h0);
        idle(2);
        rst = 1'b0;
        idle(1);
        push_frame(8'h01, 16'h0002);
        send_frame(8'h01, 8'h00, 8'h02, 8'h03);
        idle(TMO + 3);

        check("queue_drained", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
